// File: rtl/decoder_pkg.sv
// Shared constants and types for the RV32I main decoder.
// Holds opcode values, the alu_control / immediate_control / result_src
// encodings, the packed control-bundle struct and the funct3 -> ALU-op helper.
package decoder_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;

    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_UIMM = 2'b11
    } result_sel_e;

    // Complete 18-bit control bundle produced for one instruction.
    typedef struct packed {
        logic                pc_src;
        logic                pc_target_src;
        logic                u_imm_src;
        result_sel_e         result_src;
        logic                mem_write;
        logic [FUNCT3_W-1:0] mem_width;
        alu_op_e             alu_control;
        logic                alu_src;
        imm_sel_e            immediate_control;
        logic                reg_write;
    } ctrl_t;

    // funct3 -> ALU op; alt is funct7[5] already qualified by the caller.
    function automatic alu_op_e alu_from_funct3(input logic [FUNCT3_W-1:0] funct3,
                                                input logic alt);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-condition evaluation: decides whether a conditional branch is taken.
// Ports:
//   funct3             in  3  branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   equal              in  1  rs1 == rs2
//   less_than          in  1  rs1 <  rs2 signed
//   less_than_unsigned in  1  rs1 <  rs2 unsigned
//   taken              out 1  branch condition holds (combinational)
module branch_cond
    import decoder_pkg::*;
(
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                equal,
    input  logic                less_than,
    input  logic                less_than_unsigned,
    output logic                taken
);

    // Reserved encodings 010/011 never take the branch.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = equal;
            3'b001:  taken = ~equal;
            3'b100:  taken = less_than;
            3'b101:  taken = ~less_than;
            3'b110:  taken = less_than_unsigned;
            3'b111:  taken = ~less_than_unsigned;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/decoder.sv
// RV32I main decoder: instruction word plus ALU compare flags -> datapath controls.
// Build option: define DECODER_OUTPUT_REG_EN to register every output on the
// rising clk edge (1-cycle latency, synchronous active-low reset clears them).
// Without it the decoder is purely combinational and clk/reset are unused.
// Ports:
//   clk, reset                       in   clock / sync active-low reset
//   instruction                      in   32-bit RV32I instruction
//   equal, less_than,
//   less_than_unsigned               in   ALU compare flags (rs1 vs rs2)
//   pc_src, pc_target_src, u_imm_src out  PC / U-immediate path selects
//   result_src[1:0]                  out  writeback select
//   mem_write, mem_width[2:0]        out  store enable, access width (funct3)
//   alu_control[3:0], alu_src        out  ALU operation, operand B select
//   immediate_control[2:0]           out  immediate format
//   reg_write                        out  register-file write enable
module decoder
    import decoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               equal,
    input  logic               less_than,
    input  logic               less_than_unsigned,
    output logic               pc_src,
    output logic               pc_target_src,
    output logic               u_imm_src,
    output logic [1:0]         result_src,
    output logic               mem_write,
    output logic [2:0]         mem_width,
    output logic [3:0]         alu_control,
    output logic               alu_src,
    output logic [2:0]         immediate_control,
    output logic               reg_write
);

    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                funct7_b5;
    logic                br_taken;
    ctrl_t               ctrl_d;
    ctrl_t               ctrl_out;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];

    branch_cond u_branch_cond (
        .funct3             (funct3),
        .equal              (equal),
        .less_than          (less_than),
        .less_than_unsigned (less_than_unsigned),
        .taken              (br_taken)
    );

    // Main opcode decode; unlisted opcodes leave the all-zero default.
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OPC_OP: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = alu_from_funct3(funct3, funct7_b5);
            end
            OPC_OP_IMM: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                // funct7[5] only matters for shifts-right; ADDI has no SUB form.
                ctrl_d.alu_control = alu_from_funct3(funct3,
                                                     funct7_b5 && (funct3 == 3'b101));
            end
            OPC_LOAD: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.result_src = RES_LOAD;
                ctrl_d.mem_width  = funct3;
            end
            OPC_STORE: begin
                ctrl_d.mem_write         = 1'b1;
                ctrl_d.alu_src           = 1'b1;
                ctrl_d.immediate_control = IMM_S;
                ctrl_d.mem_width         = funct3;
            end
            OPC_BRANCH: begin
                ctrl_d.immediate_control = IMM_B;
                ctrl_d.alu_control       = ALU_SUB;
                ctrl_d.pc_src            = br_taken;
            end
            OPC_JAL: begin
                ctrl_d.pc_src            = 1'b1;
                ctrl_d.immediate_control = IMM_J;
                ctrl_d.reg_write         = 1'b1;
                ctrl_d.result_src        = RES_PC4;
            end
            OPC_JALR: begin
                ctrl_d.pc_src        = 1'b1;
                ctrl_d.pc_target_src = 1'b1;
                ctrl_d.alu_src       = 1'b1;
                ctrl_d.reg_write     = 1'b1;
                ctrl_d.result_src    = RES_PC4;
            end
            OPC_LUI, OPC_AUIPC: begin
                ctrl_d.reg_write         = 1'b1;
                ctrl_d.immediate_control = IMM_U;
                ctrl_d.result_src        = RES_UIMM;
                ctrl_d.u_imm_src         = (opcode == OPC_AUIPC);
            end
            default: ctrl_d = '0;
        endcase
    end

`ifdef DECODER_OUTPUT_REG_EN
    ctrl_t ctrl_q;

    // Output register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ctrl_out = ctrl_q;

    // Register/immediate fields are consumed elsewhere in the datapath.
    logic unused_c;
    assign unused_c = &{1'b0, instruction};
`else
    assign ctrl_out = ctrl_d;

    // clk/reset are only needed by the registered build.
    logic unused_c;
    assign unused_c = &{1'b0, clk, reset, instruction};
`endif

    assign pc_src            = ctrl_out.pc_src;
    assign pc_target_src     = ctrl_out.pc_target_src;
    assign u_imm_src         = ctrl_out.u_imm_src;
    assign result_src        = ctrl_out.result_src;
    assign mem_write         = ctrl_out.mem_write;
    assign mem_width         = ctrl_out.mem_width;
    assign alu_control       = ctrl_out.alu_control;
    assign alu_src           = ctrl_out.alu_src;
    assign immediate_control = ctrl_out.immediate_control;
    assign reg_write         = ctrl_out.reg_write;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder (combinational or registered build).
// Observed bundle order: {pc_src, pc_target_src, u_imm_src, result_src[1:0],
// mem_write, mem_width[2:0], alu_control[3:0], alu_src, immediate_control[2:0], reg_write}.
module tb_decoder;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        equal;
    logic        less_than;
    logic        less_than_unsigned;
    logic        pc_src;
    logic        pc_target_src;
    logic        u_imm_src;
    logic [1:0]  result_src;
    logic        mem_write;
    logic [2:0]  mem_width;
    logic [3:0]  alu_control;
    logic        alu_src;
    logic [2:0]  immediate_control;
    logic        reg_write;

    logic [17:0] obs;
    logic [17:0] exp;
    int          checks;
    int          errors;

    decoder dut (
        .clk                (clk),
        .reset              (reset),
        .instruction        (instruction),
        .equal              (equal),
        .less_than          (less_than),
        .less_than_unsigned (less_than_unsigned),
        .pc_src             (pc_src),
        .pc_target_src      (pc_target_src),
        .u_imm_src          (u_imm_src),
        .result_src         (result_src),
        .mem_write          (mem_write),
        .mem_width          (mem_width),
        .alu_control        (alu_control),
        .alu_src            (alu_src),
        .immediate_control  (immediate_control),
        .reg_write          (reg_write)
    );

    assign obs = {pc_src, pc_target_src, u_imm_src, result_src, mem_write, mem_width,
                  alu_control, alu_src, immediate_control, reg_write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs hand-written expected field values into the observed bundle order.
    function automatic logic [17:0] pack(input logic ps, input logic pts, input logic us,
                                         input logic [1:0] rs, input logic mw,
                                         input logic [2:0] wid, input logic [3:0] alu,
                                         input logic as, input logic [2:0] imm,
                                         input logic rw);
        return {ps, pts, us, rs, mw, wid, alu, as, imm, rw};
    endfunction

    // Apply one stimulus vector and wait until the outputs reflect it.
    task automatic drive(input logic [31:0] ins, input logic eq, input logic lt,
                         input logic ltu);
        instruction        = ins;
        equal              = eq;
        less_than          = lt;
        less_than_unsigned = ltu;
`ifdef DECODER_OUTPUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(32'h002081B3, 1'b0, 1'b0, 1'b0);
`ifdef DECODER_OUTPUT_REG_EN
        exp = 18'h0;
`else
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0000, 0, 3'b000, 1);
`endif
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, exp);
        end
        reset = 1'b1;
    endtask

    task automatic test_alu_ops;
        drive(32'h002081B3, 1'b1, 1'b1, 1'b1);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0000, 0, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL add: got %h expected %h", obs, exp); end

        drive(32'h402081B3, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sub: got %h expected %h", obs, exp); end

        drive(32'h4050D093, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0111, 1, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL srai: got %h expected %h", obs, exp); end

        // addi with funct7[5]=1 must still be ADD
        drive(32'h40008093, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0000, 1, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL addi_f7: got %h expected %h", obs, exp); end

        // and (funct3 111)
        drive(32'h0020F1B3, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b1001, 0, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL and: got %h expected %h", obs, exp); end
    endtask

    task automatic test_mem;
        drive(32'h0080A283, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b01, 0, 3'b010, 4'b0000, 1, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lw: got %h expected %h", obs, exp); end

        drive(32'h0000C083, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b01, 0, 3'b100, 4'b0000, 1, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lbu: got %h expected %h", obs, exp); end

        drive(32'h0050A423, 1'b1, 1'b1, 1'b1);
        exp = pack(0, 0, 0, 2'b00, 1, 3'b010, 4'b0000, 1, 3'b001, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sw: got %h expected %h", obs, exp); end
    endtask

    task automatic test_branch;
        drive(32'h00208463, 1'b1, 1'b0, 1'b0);
        exp = pack(1, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL beq_taken: got %h expected %h", obs, exp); end

        drive(32'h00208463, 1'b0, 1'b1, 1'b1);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL beq_not: got %h expected %h", obs, exp); end

        drive(32'h00209463, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bne_taken: got %h expected %h", obs, exp); end

        drive(32'h0020C463, 1'b0, 1'b1, 1'b0);
        exp = pack(1, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL blt_taken: got %h expected %h", obs, exp); end

        drive(32'h0020C463, 1'b1, 1'b0, 1'b1);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL blt_not: got %h expected %h", obs, exp); end

        drive(32'h0020D463, 1'b0, 1'b0, 1'b1);
        exp = pack(1, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bge_taken: got %h expected %h", obs, exp); end

        drive(32'h0020E463, 1'b0, 1'b0, 1'b1);
        exp = pack(1, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bltu_taken: got %h expected %h", obs, exp); end

        drive(32'h0020F463, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bgeu_taken: got %h expected %h", obs, exp); end

        drive(32'h0020F463, 1'b0, 1'b1, 1'b1);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bgeu_not: got %h expected %h", obs, exp); end

        // reserved funct3 010 never taken
        drive(32'h0020A463, 1'b1, 1'b1, 1'b1);
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b010, 0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL br_f3_010: got %h expected %h", obs, exp); end
    endtask

    task automatic test_jump_upper;
        drive(32'h008000EF, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 0, 0, 2'b10, 0, 3'b000, 4'b0000, 0, 3'b100, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL jal: got %h expected %h", obs, exp); end

        drive(32'h000100E7, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 1, 0, 2'b10, 0, 3'b000, 4'b0000, 1, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL jalr: got %h expected %h", obs, exp); end

        drive(32'h123450B7, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 2'b11, 0, 3'b000, 4'b0000, 0, 3'b011, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL lui: got %h expected %h", obs, exp); end

        drive(32'h00000097, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 1, 2'b11, 0, 3'b000, 4'b0000, 0, 3'b011, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL auipc: got %h expected %h", obs, exp); end
    endtask

    task automatic test_illegal;
        drive(32'h00000073, 1'b1, 1'b1, 1'b1);
        exp = 18'h0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ecall: got %h expected %h", obs, exp); end

        drive(32'h0000000F, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL fence: got %h expected %h", obs, exp); end

        drive(32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL illegal: got %h expected %h", obs, exp); end
    endtask

    task automatic test_back_to_back;
        drive(32'h002081B3, 1'b0, 1'b0, 1'b0);
        instruction = 32'h402081B3;
        #2;
`ifdef DECODER_OUTPUT_REG_EN
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0000, 0, 3'b000, 1);
`else
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b000, 1);
`endif
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL latency_hold: got %h expected %h", obs, exp); end

`ifdef DECODER_OUTPUT_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        exp = pack(0, 0, 0, 2'b00, 0, 3'b000, 4'b0001, 0, 3'b000, 1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL latency_update: got %h expected %h", obs, exp); end

        // reset asserted mid-stream
        drive(32'h123450B7, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(32'h123450B7, 1'b0, 1'b0, 1'b0);
`ifdef DECODER_OUTPUT_REG_EN
        exp = 18'h0;
`else
        exp = pack(0, 0, 0, 2'b11, 0, 3'b000, 4'b0000, 0, 3'b011, 1);
`endif
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid: got %h expected %h", obs, exp); end
        reset = 1'b1;
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        reset              = 1'b0;
        instruction        = 32'h0;
        equal              = 1'b0;
        less_than          = 1'b0;
        less_than_unsigned = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch();
        test_jump_upper();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
